// File: rtl/r4k_pkg.sv
// Shared constants and types for the r4k memory responder.
// MMIO offsets are relative to the responder's MMIO base.
package r4k_pkg;

  localparam logic [4:0] MMIO_CYCLE   = 5'h00;
  localparam logic [4:0] MMIO_TOHOST  = 5'h08;
  localparam logic [4:0] MMIO_ERRCNT  = 5'h10;
  localparam logic [4:0] MMIO_ERRADDR = 5'h18;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_MISALIGN,
    ERR_UNMAPPED
  } r4k_err_e;

endpackage

// File: rtl/r4k_byte_ram.sv
// 64-bit word RAM: one byte-masked write port and two read ports.
// Both reads return the contents from before a same-edge write.
module r4k_byte_ram #(
  parameter int DEPTH_WORDS = 4096
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [7:0]                     wmask,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [63:0]                    wdata,
  input  logic                           re_a,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_a,
  output logic [63:0]                    q_a,
  input  logic                           re_b,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_b,
  output logic [63:0]                    q_b
);

  logic [63:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re_a) q_a <= mem[addr_a];
    if (re_b) q_b <= mem[addr_b];
  end

endmodule

// File: rtl/r4k_mem_responder.sv
// Memory responder for r4k fetch and data buses: RAM plus a
// small MMIO window (cycle counter, tohost mailbox, error status).
module r4k_mem_responder
  import r4k_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [63:0] MMIO_BASE   = 64'hFFFF_FFFF_FFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] instr_address,
  input  logic        instr_read,
  output logic [31:0] instr_rdata,
  input  logic [63:0] data_address,
  input  logic [63:0] data_wdata,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [7:0]  data_mask,
  output logic [63:0] data_rdata,
  output logic        error,
  output logic        tohost_valid,
  output logic [63:0] tohost_value
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic        d_req, d_ram, d_mmio, d_ok;
  logic        i_ram, i_ok;
  logic [63:0] d_off;
  logic [4:0]  mmio_off;
  r4k_err_e    d_err, i_err;
  logic [1:0]  n_err;
  logic        mmio_wr, err_clr;
  logic [63:0] mmio_rdata;
  logic        ram_we, ram_re_a, ram_re_b;
  logic [63:0] ram_q_a, ram_q_b;

  logic [63:0] cycle_q;
  logic [31:0] errcnt_q;
  logic [63:0] erraddr_q;
  logic [32:0] errcnt_sum;

  logic        d_sel_ram_q;
  logic [63:0] d_hold_q;
  logic        i_sel_ram_q;
  logic        i_hi_q;

  assign d_req    = data_read | data_write;
  assign d_ram    = data_address[63:AW+3] == '0;
  assign d_off    = data_address - MMIO_BASE;
  assign d_mmio   = d_off[63:5] == '0;
  assign mmio_off = d_off[4:0];
  assign i_ram    = instr_address[63:AW+3] == '0;

  always_comb begin
    d_err = ERR_NONE;
    if (d_req) begin
      if (data_address[2:0] != 3'b000) d_err = ERR_MISALIGN;
      else if (!d_ram && !d_mmio)      d_err = ERR_UNMAPPED;
    end
  end

  // MMIO is not executable, so fetches only succeed in RAM
  always_comb begin
    i_err = ERR_NONE;
    if (instr_read) begin
      if (instr_address[1:0] != 2'b00) i_err = ERR_MISALIGN;
      else if (!i_ram)                 i_err = ERR_UNMAPPED;
    end
  end

  assign d_ok  = d_req && d_err == ERR_NONE;
  assign i_ok  = instr_read && i_err == ERR_NONE;
  assign n_err = {1'b0, d_err != ERR_NONE}
               + {1'b0, i_err != ERR_NONE};

  assign ram_we   = data_write & d_ok & d_ram;
  assign ram_re_a = data_read & d_ok & d_ram;
  assign ram_re_b = i_ok;
  assign mmio_wr  = data_write & d_ok & ~d_ram;
  assign err_clr  = mmio_wr && mmio_off == MMIO_ERRCNT;

  always_comb begin
    mmio_rdata = '0;
    unique case (1'b1)
      (mmio_off == MMIO_CYCLE):   mmio_rdata = cycle_q;
      (mmio_off == MMIO_TOHOST):  mmio_rdata = tohost_value;
      (mmio_off == MMIO_ERRCNT):  mmio_rdata = {32'h0, errcnt_q};
      (mmio_off == MMIO_ERRADDR): mmio_rdata = erraddr_q;
      default:                    mmio_rdata = '0;
    endcase
  end

  r4k_byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .wmask (data_mask),
    .waddr (data_address[AW+2:3]),
    .wdata (data_wdata),
    .re_a  (ram_re_a),
    .addr_a(data_address[AW+2:3]),
    .q_a   (ram_q_a),
    .re_b  (ram_re_b),
    .addr_b(instr_address[AW+2:3]),
    .q_b   (ram_q_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tohost_valid <= 1'b0;
      tohost_value <= '0;
    end else if (mmio_wr && mmio_off == MMIO_TOHOST) begin
      tohost_valid <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (data_mask[i]) begin
          tohost_value[8*i +: 8] <= data_wdata[8*i +: 8];
        end
      end
    end
  end

  assign errcnt_sum = {1'b0, errcnt_q} + {31'h0, n_err};

  // A clear takes priority over any error arriving in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      errcnt_q  <= '0;
      erraddr_q <= '0;
      error     <= 1'b0;
    end else if (err_clr) begin
      errcnt_q <= '0;
      error    <= 1'b0;
    end else if (n_err != 2'd0) begin
      errcnt_q <= errcnt_sum[32] ? 32'hFFFF_FFFF : errcnt_sum[31:0];
      error    <= 1'b1;
      if (errcnt_q == '0) begin
        erraddr_q <= (d_err != ERR_NONE) ? data_address
                                         : instr_address;
      end
    end
  end

  // Output selects only move on a request, so idle ports hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_sel_ram_q <= 1'b0;
      d_hold_q    <= '0;
      i_sel_ram_q <= 1'b0;
      i_hi_q      <= 1'b0;
    end else begin
      if (data_read) begin
        d_sel_ram_q <= d_ok & d_ram;
        d_hold_q    <= (d_ok && !d_ram) ? mmio_rdata : '0;
      end
      if (instr_read) begin
        i_sel_ram_q <= i_ok;
        i_hi_q      <= instr_address[2];
      end
    end
  end

  assign data_rdata  = d_sel_ram_q ? ram_q_a : d_hold_q;
  assign instr_rdata = !i_sel_ram_q ? 32'h0
                     : i_hi_q ? ram_q_b[63:32] : ram_q_b[31:0];

endmodule
